// File: rtl/mem_pkg.sv
// Shared definitions for the fetch/memory datapath slice: widths, mux encodings
// and the boot-loader state encoding.
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] RIN_MBR  = 2'b00;
  localparam logic [1:0] RIN_ACC  = 2'b01;
  localparam logic [1:0] RIN_RF   = 2'b10;
  localparam logic [1:0] RIN_ZERO = 2'b11;

  localparam logic MAR_SRC_PC  = 1'b0;
  localparam logic MAR_SRC_MBR = 1'b1;
  localparam logic MBR_SRC_RAM = 1'b0;
  localparam logic MBR_SRC_ALU = 1'b1;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } boot_state_e;

endpackage

// File: rtl/ram_256x8.sv
// Program/data RAM: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a reset mid-run keeps the program.
module ram_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_mem_unit.sv
// PC/MAR/MBR/IR datapath with a boot loader that fills RAM from a byte stream
// and then releases the control unit by raising run.
module fetch_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              MAR_we,
  input  logic              MAR_mux,
  input  logic              MBR_we,
  input  logic              MBR_mux,
  input  logic              IR_we,
  input  logic              PC_inc,
  input  logic              PC_load,
  input  logic [DATA_W-1:0] pc_load_val,
  input  logic              RAM_we,
  input  logic [1:0]        RAM_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [DATA_W-1:0] rf_in,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              run,
  output logic              load_full,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mbr_out,
  output logic [DATA_W-1:0] ir_out
);

  boot_state_e       state_q;
  logic              run_q, ready_q, full_q;
  logic [ADDR_W-1:0] load_addr_q;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d, ir_q, ir_d;
  logic [DATA_W-1:0] ram_rdata, cpu_wdata, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_we, boot_accept;

  assign boot_accept = (state_q == BOOT) && prog_valid;

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state_q     <= BOOT;
      run_q       <= 1'b0;
      ready_q     <= 1'b1;
      full_q      <= 1'b0;
      load_addr_q <= '0;
    end else if (boot_accept) begin
      load_addr_q <= load_addr_q + ADDR_W'(1);
      // The byte landing on the top address ends the boot even without prog_last.
      if (prog_last || (load_addr_q == {ADDR_W{1'b1}})) begin
        state_q <= RUN;
        run_q   <= 1'b1;
        ready_q <= 1'b0;
        full_q  <= ~prog_last;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (PC_load)     pc_d = pc_load_val[ADDR_W-1:0];
    else if (PC_inc) pc_d = pc_q + ADDR_W'(1);

    mar_d = mar_q;
    if (MAR_we) mar_d = (MAR_mux == MAR_SRC_MBR) ? mbr_q[ADDR_W-1:0] : pc_q;

    mbr_d = mbr_q;
    if (MBR_we) mbr_d = (MBR_mux == MBR_SRC_ALU) ? alu_result : ram_rdata;

    ir_d = ir_q;
    if (IR_we) ir_d = mbr_q;

    case (RAM_in)
      RIN_MBR: cpu_wdata = mbr_q;
      RIN_ACC: cpu_wdata = acc_in;
      RIN_RF:  cpu_wdata = rf_in;
      default: cpu_wdata = '0;
    endcase
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      pc_q  <= '0;
      mar_q <= '0;
      mbr_q <= '0;
      ir_q  <= '0;
    end else if (state_q == RUN) begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mbr_q <= mbr_d;
      ir_q  <= ir_d;
    end
  end

  // Single write port shared between the loader and the CPU store path.
  assign ram_we    = (state_q == BOOT) ? prog_valid  : RAM_we;
  assign ram_waddr = (state_q == BOOT) ? load_addr_q : mar_q;
  assign ram_wdata = (state_q == BOOT) ? prog_data   : cpu_wdata;

  ram_256x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i  (mem_clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(mar_q),
    .rdata_o(ram_rdata)
  );

  assign prog_ready = ready_q;
  assign run        = run_q;
  assign load_full  = full_q;
  assign pc_out     = pc_q;
  assign mar_out    = mar_q;
  assign mbr_out    = mbr_q;
  assign ir_out     = ir_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Randomized bench for fetch_mem_unit against an array-based reference model,
// plus directed boot, fetch, branch, store and reset scenarios.
module tb_fetch_mem_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       MAR_we, MAR_mux, MBR_we, MBR_mux, IR_we, PC_inc, PC_load, RAM_we;
  logic [1:0] RAM_in;
  logic [7:0] pc_load_val, alu_result, acc_in, rf_in, prog_data;
  logic       prog_valid, prog_last;
  logic       prog_ready, run, load_full;
  logic [7:0] pc_out, mar_out, mbr_out, ir_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_mem_unit dut (
    .mem_clk(clk), .mem_rst(rst),
    .MAR_we(MAR_we), .MAR_mux(MAR_mux), .MBR_we(MBR_we), .MBR_mux(MBR_mux),
    .IR_we(IR_we), .PC_inc(PC_inc), .PC_load(PC_load), .pc_load_val(pc_load_val),
    .RAM_we(RAM_we), .RAM_in(RAM_in), .alu_result(alu_result), .acc_in(acc_in),
    .rf_in(rf_in), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .run(run),
    .load_full(load_full), .pc_out(pc_out), .mar_out(mar_out),
    .mbr_out(mbr_out), .ir_out(ir_out)
  );

  // Reference model: plain architectural state, memory as an array.
  logic [7:0] ram_m [256];
  logic [7:0] pc_m = 8'h00, mar_m = 8'h00, mbr_m = 8'h00, ir_m = 8'h00, la_m = 8'h00;
  logic       run_m = 1'b0, full_m = 1'b0;
  logic [7:0] boot_b [256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_m <= 8'h00; mar_m <= 8'h00; mbr_m <= 8'h00; ir_m <= 8'h00;
      la_m <= 8'h00; run_m <= 1'b0; full_m <= 1'b0;
    end else if (!run_m) begin
      if (prog_valid) begin
        ram_m[la_m] <= prog_data;
        la_m <= la_m + 8'd1;
        if (prog_last || la_m == 8'd255) begin
          run_m  <= 1'b1;
          full_m <= !prog_last;
        end
      end
    end else begin
      if (PC_load)     pc_m <= pc_load_val;
      else if (PC_inc) pc_m <= pc_m + 8'd1;
      if (MAR_we) mar_m <= MAR_mux ? mbr_m : pc_m;
      if (MBR_we) mbr_m <= MBR_mux ? alu_result : ram_m[mar_m];
      if (IR_we)  ir_m  <= mbr_m;
      if (RAM_we) ram_m[mar_m] <= (RAM_in == 2'b00) ? mbr_m :
                                  (RAM_in == 2'b01) ? acc_in :
                                  (RAM_in == 2'b10) ? rf_in : 8'h00;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if ($time > 0) begin
      chk("pc",    pc_out,             pc_m);
      chk("mar",   mar_out,            mar_m);
      chk("mbr",   mbr_out,            mbr_m);
      chk("ir",    ir_out,             ir_m);
      chk("run",   8'(run),            8'(run_m));
      chk("ready", 8'(prog_ready),     8'(!run_m));
      chk("full",  8'(load_full),      8'(full_m));
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    MAR_we = 0; MAR_mux = 0; MBR_we = 0; MBR_mux = 0; IR_we = 0; PC_inc = 0;
    PC_load = 0; RAM_we = 0; RAM_in = 2'b00; prog_valid = 0; prog_last = 0;
  endtask

  task automatic boot_byte(input logic [7:0] d, input logic last);
    chk("ready_before_byte", 8'(prog_ready), 8'h01);
    prog_valid = 1; prog_data = d; prog_last = last;
    cyc();
    prog_valid = 0; prog_last = 0;
  endtask

  task automatic set_mar(input logic [7:0] a);
    MBR_we = 1; MBR_mux = 1; alu_result = a;
    cyc();
    MBR_we = 0; MAR_we = 1; MAR_mux = 1;
    cyc();
    MAR_we = 0; MAR_mux = 0;
  endtask

  task automatic read_ram(input logic [7:0] a, output logic [7:0] v);
    set_mar(a);
    MBR_we = 1; MBR_mux = 0;
    cyc();
    MBR_we = 0;
    v = mbr_out;
  endtask

  task automatic pulse_reset();
    rst = 1; #1;
    chk("rst_run", 8'(run), 8'h00);
    chk("rst_pc",  pc_out,  8'h00);
    chk("rst_ir",  ir_out,  8'h00);
    chk("rst_mbr", mbr_out, 8'h00);
    cyc();
    rst = 0;
  endtask

  logic [7:0] v;

  initial begin
    idle();
    pc_load_val = 0; alu_result = 0; acc_in = 0; rf_in = 0; prog_data = 0;
    #2 rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("reset_ready", 8'(prog_ready), 8'h01);
    chk("reset_full",  8'(load_full),  8'h00);

    // Full 256-byte boot without prog_last.
    for (int i = 0; i < 256; i++) begin
      boot_b[i] = 8'($urandom);
      boot_byte(boot_b[i], 1'b0);
      if (i == 254) chk("run_before_last", 8'(run), 8'h00);
    end
    chk("full_run",  8'(run),       8'h01);
    chk("full_flag", 8'(load_full), 8'h01);
    prog_valid = 1; prog_data = ~boot_b[0]; cyc(); prog_valid = 0;
    chk("full_ready_low", 8'(prog_ready), 8'h00);
    read_ram(8'h00, v);
    chk("full_ram0_kept", v, boot_b[0]);

    // Short boot, then a three-edge fetch.
    pulse_reset();
    boot_byte(8'hA1, 0); boot_byte(8'hB2, 0); boot_byte(8'hC3, 0);
    chk("run_low_midboot", 8'(run), 8'h00);
    boot_byte(8'hD4, 1);
    chk("boot4_run",  8'(run),       8'h01);
    chk("boot4_full", 8'(load_full), 8'h00);
    MAR_we = 1; MAR_mux = 0; cyc(); MAR_we = 0;
    MBR_we = 1; MBR_mux = 0; PC_inc = 1; cyc(); MBR_we = 0; PC_inc = 0;
    IR_we = 1; cyc(); IR_we = 0;
    chk("fetch_ir",  ir_out,  8'hA1);
    chk("fetch_pc",  pc_out,  8'h01);
    chk("fetch_mar", mar_out, 8'h00);
    read_ram(8'h03, v);
    chk("boot_ram3", v, 8'hD4);

    // PC wrap and load-over-increment priority.
    PC_load = 1; pc_load_val = 8'hFF; cyc(); PC_load = 0;
    PC_inc = 1; cyc(); PC_inc = 0;
    chk("pc_wrap", pc_out, 8'h00);
    PC_load = 1; PC_inc = 1; pc_load_val = 8'h10; cyc(); PC_load = 0; PC_inc = 0;
    chk("pc_prio", pc_out, 8'h10);

    // Store with a same-cycle read of the same address.
    set_mar(8'h20);
    RAM_we = 1; RAM_in = 2'b01; acc_in = 8'h5A; MBR_we = 1; MBR_mux = 0;
    cyc();
    RAM_we = 0; RAM_in = 2'b00;
    chk("store_old", mbr_out, boot_b[8'h20]);
    cyc();
    MBR_we = 0;
    chk("store_new", mbr_out, 8'h5A);

    // Randomized run phase.
    for (int i = 0; i < 2000; i++) begin
      MAR_we = 1'($urandom); MAR_mux = 1'($urandom);
      MBR_we = 1'($urandom); MBR_mux = 1'($urandom);
      IR_we = 1'($urandom); PC_inc = 1'($urandom);
      PC_load = ($urandom_range(0, 3) == 0); RAM_we = ($urandom_range(0, 2) == 0);
      RAM_in = 2'($urandom); prog_valid = 1'($urandom); prog_last = 1'($urandom);
      pc_load_val = 8'($urandom); alu_result = 8'($urandom);
      acc_in = 8'($urandom); rf_in = 8'($urandom); prog_data = 8'($urandom);
      cyc();
    end
    idle();
    PC_load = 1; pc_load_val = 8'h5C; IR_we = 1; cyc(); idle();

    // Reset mid-run, then reset mid-boot.
    pulse_reset();
    boot_byte(8'h11, 0); boot_byte(8'h22, 0);
    pulse_reset();
    chk("midboot_ready", 8'(prog_ready), 8'h01);
    boot_byte(8'hEE, 1);
    chk("reboot_run", 8'(run), 8'h01);
    read_ram(8'h00, v);
    chk("reboot_ram0", v, 8'hEE);
    read_ram(8'h01, v);
    chk("reboot_ram1", v, 8'h22);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
